branch_predictor: RTL and testbench

// - Fetch-stage direction/target predictor with execute-stage resolution. Sits upstream of hazard_unit.
// - Looks up pc_f in a bimodal BHT (2-bit counters) plus a direct-mapped BTB, and supplies the next fetch PC.
// - At E it compares the actual outcome with the prediction carried down the pipe.
// - Drives mispredict / redirect_pc_e; hazard_unit turns mispredict into the D/E/M1 flushes.

---
 rtl/branch_predictor_if.sv | 47 ++++
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup and execute resolve signals of branch_predictor.
// With BP_GSHARE_EN defined, the interface also carries ghr_f and ghr_e.
interface branch_predictor_if #(
    parameter int XLEN = 32
`ifdef BP_GSHARE_EN
    , parameter int GHR_BITS = 8
`endif
);
    logic            stall_f;
    logic [XLEN-1:0] pc_f;
    logic            pred_taken_f;
    logic [XLEN-1:0] pred_target_f;
    logic [XLEN-1:0] pc_next_f;
    logic            valid_e;
    logic            branch_e;
    logic            jump_e;
    logic            taken_e;
    logic [XLEN-1:0] pc_e;
    logic [XLEN-1:0] target_e;
    logic            pred_taken_e;
    logic [XLEN-1:0] pred_target_e;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc_e;
    logic            ready;
`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_f;
    logic [GHR_BITS-1:0] ghr_e;
`endif

    modport master (
        output pc_f, stall_f, valid_e, branch_e, jump_e, taken_e, pc_e, target_e,
               pred_taken_e, pred_target_e,
        input  pred_taken_f, pred_target_f, pc_next_f, mispredict, redirect_pc_e, ready
`ifdef BP_GSHARE_EN
        , output ghr_e, input ghr_f
`endif
    );

    modport slave (
        input  pc_f, stall_f, valid_e, branch_e, jump_e, taken_e, pc_e, target_e,
               pred_taken_e, pred_target_e,
        output pred_taken_f, pred_target_f, pc_next_f, mispredict, redirect_pc_e, ready
`ifdef BP_GSHARE_EN
        , input ghr_e, output ghr_f
`endif
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal BHT + direct-mapped BTB next-PC predictor with E-stage resolve.
// Define BP_GSHARE_EN to XOR the BHT index with a non-speculative global history register.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int BHT_BITS = 8,
    parameter int BTB_BITS = 6
`ifdef BP_GSHARE_EN
    , parameter int GHR_BITS = 8
`endif
) (
    input logic clk,
    input logic reset,
    branch_predictor_if.slave bp
);
    localparam int TAG_W = XLEN - BTB_BITS - 2;
    localparam int IDX_W = (BHT_BITS > BTB_BITS) ? BHT_BITS : BTB_BITS;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic                r_ready;
    logic [1:0]          r_bht        [2**BHT_BITS];
    logic                r_btb_valid  [2**BTB_BITS];
    logic [TAG_W-1:0]    r_btb_tag    [2**BTB_BITS];
    logic [XLEN-1:0]     r_btb_target [2**BTB_BITS];

    logic [BHT_BITS-1:0] w_bht_idx_f;
    logic [BHT_BITS-1:0] w_bht_idx_e;
    logic [BTB_BITS-1:0] w_btb_idx_f;
    logic [BTB_BITS-1:0] w_btb_idx_e;
    logic                w_hit_f;
    logic                w_pred_taken_f;
    logic [XLEN-1:0]     w_pred_target_f;
    logic                w_ctl_e;
    logic                w_upd_e;
    logic [1:0]          w_ctr_e;
    logic [1:0]          w_ctr_next;
    logic                w_unused;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;
    assign bp.ghr_f    = r_ghr;
    assign w_bht_idx_f = bp.pc_f[BHT_BITS+1:2] ^ BHT_BITS'(r_ghr);
    assign w_bht_idx_e = bp.pc_e[BHT_BITS+1:2] ^ BHT_BITS'(bp.ghr_e);
`else
    assign w_bht_idx_f = bp.pc_f[BHT_BITS+1:2];
    assign w_bht_idx_e = bp.pc_e[BHT_BITS+1:2];
`endif

    assign w_btb_idx_f = bp.pc_f[BTB_BITS+1:2];
    assign w_btb_idx_e = bp.pc_e[BTB_BITS+1:2];

    // Gating the hit with ready keeps half-initialised tables invisible during INIT.
    assign w_hit_f         = r_ready && r_btb_valid[w_btb_idx_f]
                             && (r_btb_tag[w_btb_idx_f] == bp.pc_f[XLEN-1:BTB_BITS+2]);
    assign w_pred_taken_f  = w_hit_f && r_bht[w_bht_idx_f][1];
    assign w_pred_target_f = w_hit_f ? r_btb_target[w_btb_idx_f] : '0;

    assign bp.pred_taken_f  = w_pred_taken_f;
    assign bp.pred_target_f = w_pred_target_f;
    assign bp.pc_next_f     = w_pred_taken_f ? w_pred_target_f : bp.pc_f + XLEN'(4);
    assign bp.ready         = r_ready;

    assign w_ctl_e = bp.branch_e || bp.jump_e;
    assign w_upd_e = bp.valid_e && r_ready;

    assign bp.mispredict = w_upd_e && (
        (w_ctl_e && (bp.taken_e != bp.pred_taken_e))
        || (w_ctl_e && bp.taken_e && (bp.target_e != bp.pred_target_e))
        || (!w_ctl_e && bp.pred_taken_e));
    assign bp.redirect_pc_e = (w_ctl_e && bp.taken_e) ? bp.target_e : bp.pc_e + XLEN'(4);

    assign w_ctr_e    = r_bht[w_bht_idx_e];
    assign w_ctr_next = bp.jump_e  ? 2'd3 :
                        bp.taken_e ? ((w_ctr_e == 2'd3) ? 2'd3 : w_ctr_e + 2'd1) :
                                     ((w_ctr_e == 2'd0) ? 2'd0 : w_ctr_e - 2'd1);

    assign w_unused = &{1'b0, bp.stall_f, bp.pc_f[1:0], bp.pc_e[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT;
            r_idx   <= '0;
            r_ready <= 1'b0;
        end else if (r_state == S_INIT) begin
            r_bht[BHT_BITS'(r_idx)]       <= 2'b01;
            r_btb_valid[BTB_BITS'(r_idx)] <= 1'b0;
`ifdef BP_GSHARE_EN
            r_ghr <= '0;
`endif
            r_idx <= r_idx + 1'b1;
            if (&r_idx) begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
            end
        end else if (bp.valid_e) begin
            if (w_ctl_e)
                r_bht[w_bht_idx_e] <= w_ctr_next;
            if (w_ctl_e && bp.taken_e) begin
                r_btb_valid[w_btb_idx_e]  <= 1'b1;
                r_btb_tag[w_btb_idx_e]    <= bp.pc_e[XLEN-1:BTB_BITS+2];
                r_btb_target[w_btb_idx_e] <= bp.target_e;
            end else if (!w_ctl_e && bp.pred_taken_e) begin
                r_btb_valid[w_btb_idx_e] <= 1'b0;
            end
`ifdef BP_GSHARE_EN
            if (bp.branch_e)
                r_ghr <= {r_ghr[GHR_BITS-2:0], bp.taken_e};
`endif
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for the bimodal build of branch_predictor.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32)) bp ();
    branch_predictor dut (.clk(clk), .reset(reset), .bp(bp));

    typedef struct {
        string       name;
        logic        rdy;
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] pnext;
        logic        mp;
        logic [31:0] redir;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_pass = 0;
    int   n_total = 0;

    int          ctr   [256];
    bit          bvalid[64];
    logic [31:0] btag  [64];
    logic [31:0] btgt  [64];
    int          init_left = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, act, want);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk({cur.name, ".ready"}, 32'(bp.ready), 32'(cur.rdy));
            chk({cur.name, ".pred_taken_f"}, 32'(bp.pred_taken_f), 32'(cur.pt));
            chk({cur.name, ".pred_target_f"}, bp.pred_target_f, cur.ptgt);
            chk({cur.name, ".pc_next_f"}, bp.pc_next_f, cur.pnext);
            chk({cur.name, ".mispredict"}, 32'(bp.mispredict), 32'(cur.mp));
            chk({cur.name, ".redirect_pc_e"}, bp.redirect_pc_e, cur.redir);
        end
    end

    task automatic step(input string name, input logic [31:0] pcf, input logic v, input logic br,
                        input logic jp, input logic tk, input logic [31:0] pce, input logic [31:0] tgt,
                        input logic pte, input logic [31:0] ptt, input logic rst);
        exp_t e;
        int bi, ti, be, te;
        logic ctl, rdy, hit;
        @(posedge clk);
        #1;
        reset = rst;
        bp.stall_f = 1'($urandom_range(1));
        bp.pc_f = pcf; bp.valid_e = v; bp.branch_e = br; bp.jump_e = jp; bp.taken_e = tk;
        bp.pc_e = pce; bp.target_e = tgt; bp.pred_taken_e = pte; bp.pred_target_e = ptt;
        if (rst) begin
            init_left = 256;
            for (int i = 0; i < 256; i++) ctr[i] = 1;
            for (int i = 0; i < 64; i++) bvalid[i] = 0;
            return;
        end
        rdy = (init_left == 0);
        bi = int'((pcf >> 2) % 256);
        ti = int'((pcf >> 2) % 64);
        hit = rdy && bvalid[ti] && (btag[ti] == (pcf >> 8));
        ctl = br || jp;
        e.name  = name;
        e.rdy   = rdy;
        e.pt    = hit && (ctr[bi] >= 2);
        e.ptgt  = hit ? btgt[ti] : 32'h0;
        e.pnext = e.pt ? e.ptgt : pcf + 32'd4;
        e.mp    = v && rdy && (ctl ? ((tk != pte) || (tk && tgt != ptt)) : pte);
        e.redir = (ctl && tk) ? tgt : pce + 32'd4;
        exp_q.push_back(e);
        if (!rdy) init_left--;
        else if (v) begin
            be = int'((pce >> 2) % 256);
            te = int'((pce >> 2) % 64);
            if (jp) ctr[be] = 3;
            else if (br) ctr[be] = tk ? ((ctr[be] == 3) ? 3 : ctr[be] + 1) : ((ctr[be] == 0) ? 0 : ctr[be] - 1);
            if (ctl && tk) begin
                bvalid[te] = 1; btag[te] = pce >> 8; btgt[te] = tgt;
            end else if (!ctl && pte) bvalid[te] = 0;
        end
    endtask

    task automatic idle(input string name, input logic [31:0] pcf);
        step(name, pcf, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(3))
            0: return 32'h200 + 4 * $urandom_range(15);
            1: return 32'h1200 + 4 * $urandom_range(15);
            2: return 32'hFFFF_FFFC - 4 * $urandom_range(3);
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic rnd_step(input string name);
        int kind;
        logic tk;
        logic [31:0] pce, tgt;
        kind = $urandom_range(2);
        tk   = (kind == 1) ? 1'b1 : 1'($urandom_range(1));
        pce  = pick();
        tgt  = pick();
        step(name, $urandom_range(1) ? pce : pick(), ($urandom_range(4) != 0), (kind == 0), (kind == 1),
             tk, pce, tgt, 1'($urandom_range(1)), $urandom_range(1) ? tgt : pick(), 0);
    endtask

    initial begin
        bp.pc_f = '0; bp.stall_f = 0; bp.valid_e = 0; bp.branch_e = 0; bp.jump_e = 0; bp.taken_e = 0;
        bp.pc_e = '0; bp.target_e = '0; bp.pred_taken_e = 0; bp.pred_target_e = '0;
        step("reset", 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
        for (int i = 0; i < 256; i++)
            step("init", pick(), 1, 1, 0, 1, 32'h200, 32'h180, 0, 32'h0, 0);
        idle("boot_pc100", 32'h100);
        step("br_taken", 32'h100, 1, 1, 0, 1, 32'h200, 32'h180, 0, 32'h0, 0);
        idle("btb_hit", 32'h200);
        step("br_nt1", 32'h200, 1, 1, 0, 0, 32'h200, 32'h180, 1, 32'h180, 0);
        step("br_nt2", 32'h200, 1, 1, 0, 0, 32'h200, 32'h180, 1, 32'h180, 0);
        idle("ctr_zero", 32'h200);
        step("jal", 32'h100, 1, 0, 1, 1, 32'h300, 32'h400, 1, 32'h3F0, 0);
        idle("jal_hit", 32'h300);
        step("nonctl", 32'h300, 1, 0, 0, 0, 32'h500, 32'h0, 1, 32'h0, 0);
        idle("invalidated", 32'h300);
        step("bubble", 32'h200, 0, 1, 0, 1, 32'h200, 32'h180, 0, 32'h0, 0);
        idle("bubble_chk", 32'h200);
        idle("wrap", 32'hFFFF_FFFC);
        for (int i = 0; i < 400; i++) rnd_step("rand");
        step("mid_reset", 32'h200, 1, 1, 0, 1, 32'h200, 32'h180, 0, 32'h0, 1);
        step("after_reset", 32'h200, 1, 1, 0, 1, 32'h200, 32'h180, 0, 32'h0, 0);
        for (int i = 0; i < 260; i++) idle("reinit", pick());
        step("rerun_br", 32'h200, 1, 1, 0, 1, 32'h200, 32'h180, 0, 32'h0, 0);
        idle("rerun_hit", 32'h200);
        for (int i = 0; i < 100; i++) rnd_step("rand2");
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
